// File: rtl/mips_pkg.sv
// Shared types for the MIPS HI/LO multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration on {acc, q}: shift-add for multiply, restoring subtract for divide.
module mips_muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   sh_s;
  logic [XLEN-1:0] diff_s;
  logic            ge_s;

  // Multiply consumes q from the LSB; divide shifts dividend bits in from the MSB of q.
  always_comb begin
    sum_s  = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : {(XLEN+1){1'b0}});
    sh_s   = {acc_i, q_i[XLEN-1]};
    ge_s   = (sh_s >= {1'b0, m_i});
    diff_s = sh_s[XLEN-1:0] - m_i;
    if (is_div_i) begin
      if (ge_s) begin
        acc_o = diff_s;
        q_o   = {q_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = sh_s[XLEN-1:0];
        q_o   = {q_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = sum_s[XLEN:1];
      q_o   = {sum_s[0], q_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: operand latch, XLEN-step iteration, sign fixup,
// and the architectural HI/LO registers including MTHI/MTLO writes.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            cancel,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] qr_q, qr_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            is_div_q, is_div_d;
  logic            neg_p_q, neg_p_d;
  logic            neg_r_q, neg_r_d;
  logic            dz_q, dz_d;
  logic            dbz_q, dbz_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  muldiv_op_t      op_s;
  logic            a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN-1:0] step_acc_s, step_q_s;
  logic [2*XLEN-1:0] prod_s, prod_neg_s;
  logic [XLEN-1:0] quot_neg_s, rem_neg_s;
  logic            done_s;

  mips_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .q_i      (qr_q),
    .m_i      (m_q),
    .acc_o    (step_acc_s),
    .q_o      (step_q_s)
  );

  // Operand magnitudes and final negations; MIN's magnitude is correct as an unsigned value.
  always_comb begin
    op_s       = muldiv_op_t'(req_op);
    a_neg_s    = op_is_signed(op_s) & req_a[XLEN-1];
    b_neg_s    = op_is_signed(op_s) & req_b[XLEN-1];
    a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - req_a) : req_a;
    b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - req_b) : req_b;
    prod_s     = {acc_q, qr_q};
    prod_neg_s = {(2*XLEN){1'b0}} - prod_s;
    quot_neg_s = {XLEN{1'b0}} - qr_q;
    rem_neg_s  = {XLEN{1'b0}} - acc_q;
  end

  // Next-state, datapath loads and HI/LO update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wr_data;
        else       hi_d = hi_q;
        if (lo_we) lo_d = wr_data;
        else       lo_d = lo_q;
        if (req_valid) begin
          state_d  = RUN;
          cnt_d    = {CNT_W{1'b0}};
          acc_d    = {XLEN{1'b0}};
          is_div_d = op_is_div(op_s);
          m_d      = op_is_div(op_s) ? b_mag_s : a_mag_s;
          qr_d     = op_is_div(op_s) ? a_mag_s : b_mag_s;
          a_d      = req_a;
          neg_p_d  = a_neg_s ^ b_neg_s;
          neg_r_d  = a_neg_s;
          dz_d     = (req_b == {XLEN{1'b0}});
          dbz_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc_s;
          qr_d  = step_q_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = FIX;
          else                   state_d = RUN;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (cancel) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
          dbz_d  = is_div_q & dz_q;
          if (is_div_q && dz_q) begin
            hi_d = a_q;
            lo_d = {XLEN{1'b1}};
          end else if (is_div_q) begin
            lo_d = neg_p_q ? quot_neg_s : qr_q;
            hi_d = neg_r_q ? rem_neg_s : acc_q;
          end else begin
            {hi_d, lo_d} = neg_p_q ? prod_neg_s : prod_s;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {XLEN{1'b0}};
      qr_q     <= {XLEN{1'b0}};
      m_q      <= {XLEN{1'b0}};
      a_q      <= {XLEN{1'b0}};
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_s;
  // The flag must already be visible in the done cycle, before dbz_q loads.
  assign div_by_zero = dbz_q | (done_s & is_div_q & dz_q);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (XLEN=64 plus one XLEN=32 instance).
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, cancel, hi_we, lo_we, busy, done, div_by_zero;
  logic [1:0]  req_op;
  logic [63:0] req_a, req_b, wr_data, hi, lo;

  logic        v32, rdy32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  mips_muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32),
    .req_op(op32), .req_a(a32), .req_b(b32), .cancel(1'b0),
    .hi_we(1'b0), .lo_we(1'b0), .wr_data(32'd0), .hi(hi32), .lo(lo32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept happens at the posedge between the two negedges; returns at cycle k=1.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic dz);
    lat = 0;
    dz  = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        lat = k;
        dz  = div_by_zero;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic dz1, output logic dz);
    issue(op, a, b);
    dz1 = div_by_zero;
    wait_done(lat, dz);
  endtask

  initial begin
    int   lat, ndone;
    logic dz, dz1;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 64'd0; req_b = 64'd0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = 64'd0;
    v32 = 1'b0; op32 = 2'b00; a32 = 32'd0; b32 = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_hi", hi, 128'd0);
    check_eq("rst_lo", lo, 128'd0);
    check_eq("rst_flags", {req_ready, busy, done, div_by_zero}, 128'b1000);

    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, dz1, dz);
    check_eq("multu_lat", lat, 128'd65);
    check_eq("multu_hi", hi, 128'd1);
    check_eq("multu_lo", lo, 128'hFFFF_FFFF_FFFF_FFFE);

    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, lat, dz1, dz);
    check_eq("mult_hi", hi, 128'hFFFF_FFFF_FFFF_FFFF);
    check_eq("mult_lo", lo, 128'hFFFF_FFFF_FFFF_FFEB);

    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, dz1, dz);
    check_eq("div_neg_lo", lo, 128'hFFFF_FFFF_FFFF_FFFD);
    check_eq("div_neg_hi", hi, 128'hFFFF_FFFF_FFFF_FFFF);

    run_op(2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, lat, dz1, dz);
    check_eq("div_negb_lo", lo, 128'hFFFF_FFFF_FFFF_FFFD);
    check_eq("div_negb_hi", hi, 128'd1);

    run_op(2'b11, 64'd100, 64'd0, lat, dz1, dz);
    check_eq("dz_lat", lat, 128'd65);
    check_eq("dz_flag_done", dz, 128'd1);
    check_eq("dz_lo", lo, 128'hFFFF_FFFF_FFFF_FFFF);
    check_eq("dz_hi", hi, 128'd100);
    check_eq("dz_held", div_by_zero, 128'd1);

    run_op(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, dz1, dz);
    check_eq("dz_clear_on_accept", dz1, 128'd0);
    check_eq("ovf_flag", dz, 128'd0);
    check_eq("ovf_lo", lo, 128'h8000_0000_0000_0000);
    check_eq("ovf_hi", hi, 128'd0);

    run_op(2'b01, 64'h1234, 64'h10, lat, dz1, dz);
    check_eq("multu_small", {hi, lo}, 128'h12340);

    // Cancel while iterating: no done, HI/LO untouched.
    issue(2'b00, 64'd5, 64'd5);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    check_eq("cancel_run_done", done, 128'd0);
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel_run_idle", {req_ready, busy}, 128'b10);
    check_eq("cancel_run_hilo", {hi, lo}, 128'h12340);
    ndone = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("cancel_run_nodone", ndone, 128'd0);

    // Cancel in the FIX cycle wins over completion.
    issue(2'b01, 64'd2, 64'd3);
    repeat (64) @(negedge clk);
    check_eq("fix_busy", busy, 128'd1);
    cancel = 1'b1;
    #1;
    check_eq("cancel_fix_done", done, 128'd0);
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel_fix_hilo", {hi, lo}, 128'h12340);
    check_eq("cancel_fix_idle", busy, 128'd0);

    // MTHI while busy is dropped.
    issue(2'b01, 64'd1, 64'd1);
    hi_we = 1'b1; wr_data = 64'h55;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi_busy", hi, 128'd0);
    wait_done(lat, dz);
    check_eq("one_x_one", {hi, lo}, 128'd1);

    hi_we = 1'b1; wr_data = 64'h55;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi_idle_hi", hi, 128'h55);
    check_eq("mthi_idle_lo", lo, 128'd1);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 64'h77;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check_eq("mthilo_both", {hi, lo}, {64'h77, 64'h77});

    // Write lands with the accept, result overwrites at completion.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 64'd3; req_b = 64'd5;
    hi_we = 1'b1; wr_data = 64'h99;
    @(negedge clk);
    req_valid = 1'b0; hi_we = 1'b0;
    check_eq("wr_with_accept", hi, 128'h99);
    wait_done(lat, dz);
    check_eq("wr_then_result", {hi, lo}, 128'd15);

    // Reset mid-operation.
    issue(2'b11, 64'd1000, 64'd7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_hilo", {hi, lo}, 128'd0);
    check_eq("midrst_idle", {req_ready, busy}, 128'b10);
    ndone = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("midrst_nodone", ndone, 128'd0);

    // XLEN=32 instance, same MULTU case.
    @(negedge clk);
    v32 = 1'b1; op32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
    @(negedge clk);
    v32 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done32) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("x32_lat", lat, 128'd33);
    check_eq("x32_hi", hi32, 128'd1);
    check_eq("x32_lo", lo32, 128'hFFFF_FFFE);
    check_eq("x32_flags", {rdy32, busy32, dbz32}, 128'b100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
